lfsr_word_serializer: RTL and testbench
=======================================

Name: lfsr_word_serializer

Overview:
- Downstream consumer of the N-bit, M-word parallel Fibonacci LFSR.
- Captures one M*N-bit block per request and drives the LFSR enable, so each block is consumed exactly once.
- Streams the block out one N-bit word per cycle on a valid/ready interface, with a one-block prefetch buffer for bubble-free throughput.
- Feeds word-oriented consumers (scramblers, test-pattern sinks) and keeps a running count of accepted words.

Parameters:
- LFSR_N, 8: word width in bits; must match the LFSR.
- LFSR_M, 4: words per block; must match the LFSR; must be >= 1.
- MSW_FIRST, 0: 0 = word 0 (i_blk[N-1:0]) is sent first; 1 = word M-1 is sent first.
- CNT_W, 16: width of the accepted-word counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_flush  in  1  synchronous flush; discards all buffered data.
- i_blk  in  LFSR_M*LFSR_N  parallel LFSR output (o_LFSR_val).
- o_blk_req  out  1  block request; drives the LFSR enable (i_LFSR_enable).
- o_word  out  LFSR_N  current output word.
- o_valid  out  1  o_word is valid.
- i_ready  in  1  downstream accepts o_word this cycle.
- o_last  out  1  o_word is the final word of its block.
- o_word_cnt  out  CNT_W  number of accepted words; wraps modulo 2^CNT_W.

Behaviour:
- Storage:
  - shift register sreg with flag s_full and index idx (0..M-1);
  - prefetch register pre with flag pre_full.
- Reset (async, i_rst=1):
  - s_full=0, pre_full=0, idx=0, sreg=0, pre=0, o_word_cnt=0;
  - o_valid=0, o_last=0, o_word=0;
  - o_blk_req forced 0 while i_rst=1.
- o_blk_req = ~pre_full & ~i_flush & ~i_rst (combinational).
  - When it is high, the LFSR advances on the same edge the block is captured, so the captured value is the pre-advance i_blk.
- o_valid = s_full & ~i_flush. A transfer (xfer) occurs when o_valid & i_ready.
- o_word selection:
  - MSW_FIRST=0: o_word = sreg word idx.
  - MSW_FIRST=1: o_word = sreg word (M-1-idx).
- o_last = o_valid & (idx == M-1).
- Per edge, in priority order:
  1. i_flush: s_full<=0, pre_full<=0, idx<=0. Counter unchanged. No capture.
  2. Define pop_last = xfer & (idx == M-1), and sreg_free = ~s_full | pop_last.
  3. sreg_free & pre_full: sreg<=pre, idx<=0, s_full<=1, pre_full<=0.
  4. Else sreg_free & o_blk_req: sreg<=i_blk, idx<=0, s_full<=1 (direct load bypasses pre).
  5. Else o_blk_req (sreg busy): pre<=i_blk, pre_full<=1.
  6. Else sreg_free: s_full<=0.
  7. xfer & ~pop_last: idx<=idx+1.
  8. xfer: o_word_cnt<=o_word_cnt+1, wrapping from 2^CNT_W-1 to 0.
- Latency: the first o_valid is asserted in the cycle after the first request edge following reset release (1 cycle).
- Throughput: with i_ready held at 1, one word per cycle with no bubbles for every M >= 1.
- Backpressure:
  - o_word, o_last and idx are held stable while o_valid & ~i_ready.
  - Once pre_full=1, o_blk_req stays 0, so the LFSR stalls.
  - No block is ever dropped or duplicated.
- Simultaneous events:
  - When pop_last and pre_full coincide, the transfer completes and sreg reloads from pre on the same edge.
  - The flush cycle cannot produce a transfer, because o_valid is forced 0.
- Reset mid-operation: state clears immediately regardless of handshake; the first block after release is a fresh request.

Test Plan:
1. Reset release, i_blk held at 32'hC3A15E7F, i_ready=1 -> o_blk_req=1 in cycle 0; o_valid from cycle 1; words 7F,5E,A1,C3; o_last=1 only with C3.
2. Source model increments the block on each request (32'h03020100, 32'h07060504, ...), i_ready=1 for 16 cycles -> words 00..0F back-to-back, no o_valid gaps, o_word_cnt=16.
3. Same source, i_ready=0 for cycles 3-6 -> o_word frozen at 02; o_blk_req drops once pre is filled; after resume, words 03..0B in order, none missing or repeated.
4. i_flush pulsed after words 00,01 are accepted -> o_valid=0 and o_blk_req=0 in the flush cycle; the next word out is word 0 of the next source block (08); o_word_cnt=2.
5. MSW_FIRST=1, i_blk=32'hC3A15E7F -> words C3,A1,5E,7F; o_last with 7F.
6. CNT_W=4, 18 words accepted, then i_rst asserted asynchronously mid-cycle -> o_word_cnt reads 2 before reset; o_valid, o_blk_req and o_word_cnt go 0 immediately on i_rst, without waiting for a clock edge.

Source files
------------

// File: rtl/lfsr_word_serializer_if.sv
// Block/stream bundle between an LFSR source, the serializer and a word sink.
//   blk      parallel LFSR block (M words of N bits)
//   blk_req  block request; doubles as the LFSR advance enable
//   word     current output word
//   valid    word is valid
//   ready    sink accepts word this cycle
//   last     word is the final word of its block
// master: serializer side; slave: source/sink side.
interface lfsr_word_serializer_if #(
   parameter int N = 8,
   parameter int M = 4
);
   logic [M*N-1:0] blk;
   logic           blk_req;
   logic [N-1:0]   word;
   logic           valid;
   logic           ready;
   logic           last;

   modport master (input blk, ready, output blk_req, word, valid, last);
   modport slave  (output blk, ready, input blk_req, word, valid, last);
endinterface

// File: rtl/lfsr_word_serializer.sv
// Captures one M*N-bit LFSR block per request and streams it out one N-bit
// word per cycle, with a one-block prefetch buffer for bubble-free output.
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_flush     synchronous flush of all buffered data
//   bus         block input / request and word stream (master modport)
//   o_word_cnt  running count of accepted words, wraps
module lfsr_word_serializer #(
   parameter int LFSR_N    = 8,
   parameter int LFSR_M    = 4,
   parameter int MSW_FIRST = 0,
   parameter int CNT_W     = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_flush,
   lfsr_word_serializer_if.master       bus,
   output logic [CNT_W-1:0]             o_word_cnt
);
   localparam int IW = (LFSR_M > 1) ? $clog2(LFSR_M) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(LFSR_M - 1);

   logic [LFSR_M*LFSR_N-1:0] sreg;
   logic [LFSR_M*LFSR_N-1:0] pre;
   logic                     s_full;
   logic                     pre_full;
   logic [IW-1:0]            idx;
   logic [IW-1:0]            sel;
   logic                     xfer;
   logic                     at_last;
   logic                     pop_last;
   logic                     sreg_free;

   assign bus.blk_req = ~pre_full & ~i_flush & ~i_rst;
   assign bus.valid   = s_full & ~i_flush;
   assign at_last     = (idx == IDX_LAST);
   assign bus.last    = bus.valid & at_last;
   assign xfer        = bus.valid & bus.ready;
   assign pop_last    = xfer & at_last;
   // sreg can take a new block on the same edge its last word leaves
   assign sreg_free   = ~s_full | pop_last;

   assign sel      = (MSW_FIRST != 0) ? (IDX_LAST - idx) : idx;
   assign bus.word = sreg[32'(sel)*LFSR_N +: LFSR_N];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sreg       <= '0;
         pre        <= '0;
         s_full     <= 1'b0;
         pre_full   <= 1'b0;
         idx        <= '0;
         o_word_cnt <= '0;
      end else if (i_flush) begin
         s_full   <= 1'b0;
         pre_full <= 1'b0;
         idx      <= '0;
      end else begin
         if (sreg_free && pre_full) begin
            sreg     <= pre;
            idx      <= '0;
            s_full   <= 1'b1;
            pre_full <= 1'b0;
         end else if (sreg_free && bus.blk_req) begin
            // direct load: the buffer is empty, skip it
            sreg   <= bus.blk;
            idx    <= '0;
            s_full <= 1'b1;
         end else if (bus.blk_req) begin
            pre      <= bus.blk;
            pre_full <= 1'b1;
         end else if (sreg_free) begin
            s_full <= 1'b0;
         end

         if (xfer && !pop_last)
            idx <= idx + IW'(1);
         if (xfer)
            o_word_cnt <= o_word_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_lfsr_word_serializer.sv
module tb_lfsr_word_serializer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   lfsr_word_serializer_if #(.N(8), .M(4)) bus_a ();
   lfsr_word_serializer_if #(.N(8), .M(4)) bus_b ();
   lfsr_word_serializer_if #(.N(8), .M(4)) bus_c ();
   logic [15:0] cnt_a;
   logic [15:0] cnt_b;
   logic [3:0]  cnt_c;

   lfsr_word_serializer #(.LFSR_N(8), .LFSR_M(4), .MSW_FIRST(0), .CNT_W(16)) u_a (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus_a), .o_word_cnt(cnt_a));
   lfsr_word_serializer #(.LFSR_N(8), .LFSR_M(4), .MSW_FIRST(1), .CNT_W(16)) u_b (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus_b), .o_word_cnt(cnt_b));
   lfsr_word_serializer #(.LFSR_N(8), .LFSR_M(4), .MSW_FIRST(0), .CNT_W(4)) u_c (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus_c), .o_word_cnt(cnt_c));

   int          n_chk = 0;
   int          n_pass = 0;
   int          ka = 0;
   int          kc = 0;
   bit          inc_a = 1'b0;
   logic [31:0] fix_a = 32'hC3A15E7F;
   logic        rdy_a = 1'b1;
   logic        rdy_c = 1'b1;
   int          exp_w;

   function automatic logic [31:0] blkv(int k);
      logic [7:0] b;
      b = 8'(k * 4);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic settle();
      bus_a.blk   = inc_a ? blkv(ka) : fix_a;
      bus_a.ready = rdy_a;
      bus_b.blk   = 32'hC3A15E7F;
      bus_b.ready = 1'b1;
      bus_c.blk   = blkv(kc);
      bus_c.ready = rdy_c;
      #1;
   endtask

   // one rising edge; the source advances whenever its request was high
   task automatic step();
      logic ra, rc;
      ra = bus_a.blk_req;
      rc = bus_c.blk_req;
      @(posedge clk);
      if (ra) ka++;
      if (rc) kc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      flush = 1'b0;
      ka = 0;
      kc = 0;
      rdy_a = 1'b1;
      rdy_c = 1'b1;
      settle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] t1 [4];
      logic [7:0] t5 [4];
      t1 = '{8'h7F, 8'h5E, 8'hA1, 8'hC3};
      t5 = '{8'hC3, 8'hA1, 8'h5E, 8'h7F};

      // reset state
      settle();
      chk("rst_valid", 32'(bus_a.valid), 0);
      chk("rst_req", 32'(bus_a.blk_req), 0);
      chk("rst_word", 32'(bus_a.word), 0);
      chk("rst_last", 32'(bus_a.last), 0);
      chk("rst_cnt", 32'(cnt_a), 0);

      // 1: fixed block, LSW first
      inc_a = 1'b0;
      do_reset();
      for (int c = 0; c <= 4; c++) begin
         settle();
         if (c == 0) begin
            chk("t1_req0", 32'(bus_a.blk_req), 1);
            chk("t1_valid0", 32'(bus_a.valid), 0);
         end else begin
            chk("t1_valid", 32'(bus_a.valid), 1);
            chk("t1_word", 32'(bus_a.word), 32'(t1[c-1]));
            chk("t1_last", 32'(bus_a.last), (c == 4) ? 1 : 0);
         end
         step();
      end

      // 2: incrementing source, back-to-back
      inc_a = 1'b1;
      do_reset();
      for (int c = 0; c <= 16; c++) begin
         settle();
         if (c == 0) chk("t2_valid0", 32'(bus_a.valid), 0);
         else begin
            chk("t2_valid", 32'(bus_a.valid), 1);
            chk("t2_word", 32'(bus_a.word), 32'(c - 1));
            chk("t2_last", 32'(bus_a.last), ((c - 1) % 4 == 3) ? 1 : 0);
         end
         step();
      end
      settle();
      chk("t2_cnt", 32'(cnt_a), 16);

      // 3: backpressure in cycles 3..6
      do_reset();
      exp_w = 0;
      for (int c = 0; c < 40 && exp_w < 12; c++) begin
         rdy_a = !(c >= 3 && c <= 6);
         settle();
         if (c == 5) chk("t3_req_stall", 32'(bus_a.blk_req), 0);
         if (c >= 3 && c <= 6) chk("t3_frozen", 32'(bus_a.word), 32'h02);
         if (c >= 1) begin
            chk("t3_valid", 32'(bus_a.valid), 1);
            chk("t3_word", 32'(bus_a.word), 32'(exp_w));
            if (rdy_a && bus_a.valid) exp_w++;
         end
         step();
      end
      chk("t3_count", 32'(exp_w), 12);
      rdy_a = 1'b1;

      // 4: flush after two words
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         flush = (c == 3);
         settle();
         if (c == 1 || c == 2) chk("t4_word", 32'(bus_a.word), 32'(c - 1));
         if (c == 3) begin
            chk("t4_flush_valid", 32'(bus_a.valid), 0);
            chk("t4_flush_req", 32'(bus_a.blk_req), 0);
            chk("t4_flush_cnt", 32'(cnt_a), 2);
         end
         if (c == 4) chk("t4_post_valid", 32'(bus_a.valid), 0);
         if (c == 5) begin
            chk("t4_next_valid", 32'(bus_a.valid), 1);
            chk("t4_next_word", 32'(bus_a.word), 32'h08);
            chk("t4_cnt", 32'(cnt_a), 2);
         end
         step();
      end
      flush = 1'b0;

      // 5: MSW first
      do_reset();
      for (int c = 0; c <= 4; c++) begin
         settle();
         if (c >= 1) begin
            chk("t5_word", 32'(bus_b.word), 32'(t5[c-1]));
            chk("t5_last", 32'(bus_b.last), (c == 4) ? 1 : 0);
         end
         step();
      end

      // 6: 4-bit counter wrap, then async reset between edges
      do_reset();
      for (int c = 0; c <= 18; c++) begin
         settle();
         if (c >= 1) chk("t6_word", 32'(bus_c.word), 32'((c - 1) & 8'hFF));
         step();
      end
      settle();
      chk("t6_cnt_wrap", 32'(cnt_c), 2);
      chk("t6_valid_pre", 32'(bus_c.valid), 1);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(bus_c.valid), 0);
      chk("t6_rst_req", 32'(bus_c.blk_req), 0);
      chk("t6_rst_cnt", 32'(cnt_c), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
